// File: rtl/tl_buffer_param_if.sv
// tl_buffer_param_if: one valid/ready/bits channel; master drives valid+bits, slave drives ready
interface tl_buffer_param_if #(parameter int W = 1);
  logic valid;
  logic ready;
  logic [W-1:0] bits;
  modport master(output valid, bits, input ready);
  modport slave(input valid, bits, output ready);
endinterface

// File: rtl/tl_buffer_param.sv
// tl_buffer_param: TL-UL A/D buffer (per-channel FIFO depth/flow/pipe, inflight limiter); ports clock, reset, in_a/out_d slave, out_a/in_d master, a_count, d_count, inflight
module tl_buffer_param #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int SIZE_W = 4,
  parameter int SRC_W = 4,
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter bit A_FLOW = 0,
  parameter bit A_PIPE = 0,
  parameter bit D_FLOW = 0,
  parameter bit D_PIPE = 0,
  parameter int MAX_INFLIGHT = 0,
  localparam int ACW = A_DEPTH > 0 ? $clog2(A_DEPTH + 1) : 1,
  localparam int DCW = D_DEPTH > 0 ? $clog2(D_DEPTH + 1) : 1,
  localparam int IF_W = MAX_INFLIGHT > 0 ? $clog2(MAX_INFLIGHT + 1) : 1
) (
  input  logic clock,
  input  logic reset,
  tl_buffer_param_if.slave in_a,
  tl_buffer_param_if.master out_a,
  tl_buffer_param_if.slave out_d,
  tl_buffer_param_if.master in_d,
  output logic [ACW-1:0] a_count,
  output logic [DCW-1:0] d_count,
  output logic [IF_W-1:0] inflight
);
  localparam int MASK_W = DATA_W / 8;
  localparam int LB = $clog2(MASK_W);
  localparam int BW = 1 << SIZE_W;
  localparam int A_W = 3 + 3 + SIZE_W + SRC_W + ADDR_W + 7 + MASK_W + DATA_W + 1;
  localparam int D_W = 3 + 2 + SIZE_W + SRC_W + 1 + 1 + DATA_W + 1;
  function automatic logic [BW-1:0] extra(input logic [SIZE_W-1:0] s, input logic data);
    return data && s > SIZE_W'(LB) ? (BW'(1) << (s - SIZE_W'(LB))) - BW'(1) : '0;
  endfunction
  logic a_deq_valid, a_deq_ready, a_enq_ready;
  logic [A_W-1:0] a_deq_bits;
  logic d_deq_valid, d_enq_ready;
  logic [D_W-1:0] d_deq_bits;
  if (A_DEPTH > 0) begin : g_a
    localparam int PW = A_DEPTH > 1 ? $clog2(A_DEPTH) : 1;
    logic [A_W-1:0] mem [A_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [ACW-1:0] cnt;
    logic empty, flow, wr, rd;
    always_comb begin
      empty = cnt == '0;
      flow = A_FLOW && empty;
      a_deq_valid = !empty || (flow && in_a.valid);
      a_deq_bits = flow ? in_a.bits : mem[rp];
      a_enq_ready = cnt != ACW'(A_DEPTH) || (A_PIPE && a_deq_ready);
      wr = in_a.valid && a_enq_ready && !(flow && a_deq_ready);
      rd = a_deq_valid && a_deq_ready && !flow;
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (wr) begin
          mem[wp] <= in_a.bits;
          wp <= wp == PW'(A_DEPTH - 1) ? '0 : wp + 1'b1;
        end
        if (rd) rp <= rp == PW'(A_DEPTH - 1) ? '0 : rp + 1'b1;
        cnt <= cnt + ACW'(wr) - ACW'(rd);
      end
    end
    assign a_count = cnt;
  end else begin : g_a
    assign a_deq_valid = in_a.valid;
    assign a_deq_bits = in_a.bits;
    assign a_enq_ready = a_deq_ready;
    assign a_count = '0;
  end
  if (D_DEPTH > 0) begin : g_d
    localparam int PW = D_DEPTH > 1 ? $clog2(D_DEPTH) : 1;
    logic [D_W-1:0] mem [D_DEPTH];
    logic [PW-1:0] wp, rp;
    logic [DCW-1:0] cnt;
    logic empty, flow, wr, rd;
    always_comb begin
      empty = cnt == '0;
      flow = D_FLOW && empty;
      d_deq_valid = !empty || (flow && out_d.valid);
      d_deq_bits = flow ? out_d.bits : mem[rp];
      d_enq_ready = cnt != DCW'(D_DEPTH) || (D_PIPE && in_d.ready);
      wr = out_d.valid && d_enq_ready && !(flow && in_d.ready);
      rd = d_deq_valid && in_d.ready && !flow;
    end
    always_ff @(posedge clock) begin
      if (reset) begin
        wp <= '0;
        rp <= '0;
        cnt <= '0;
      end else begin
        if (wr) begin
          mem[wp] <= out_d.bits;
          wp <= wp == PW'(D_DEPTH - 1) ? '0 : wp + 1'b1;
        end
        if (rd) rp <= rp == PW'(D_DEPTH - 1) ? '0 : rp + 1'b1;
        cnt <= cnt + DCW'(wr) - DCW'(rd);
      end
    end
    assign d_count = cnt;
  end else begin : g_d
    assign d_deq_valid = out_d.valid;
    assign d_deq_bits = out_d.bits;
    assign d_enq_ready = in_d.ready;
    assign d_count = '0;
  end
  logic [BW-1:0] a_rem, d_rem;
  logic [IF_W-1:0] inflight_q;
  logic gate, a_first, a_fire, d_fire, d_last, inc, dec;
  logic a_data, d_data;
  logic [SIZE_W-1:0] a_size, d_size;
  // a_rem/d_rem hold beats still to come in the current burst; zero means the next beat opens one
  assign a_first = a_rem == '0;
  assign gate = MAX_INFLIGHT > 0 && a_first && inflight_q == IF_W'(MAX_INFLIGHT);
  assign a_deq_ready = out_a.ready && !gate;
  assign out_a.valid = a_deq_valid && !gate;
  assign out_a.bits = a_deq_bits;
  assign in_a.ready = a_enq_ready;
  assign in_d.valid = d_deq_valid;
  assign in_d.bits = d_deq_bits;
  assign out_d.ready = d_enq_ready;
  assign inflight = inflight_q;
  always_comb begin
    a_data = !a_deq_bits[A_W-1];
    a_size = a_deq_bits[A_W-7 -: SIZE_W];
    d_data = out_d.bits[D_W-1 -: 3] == 3'd1;
    d_size = out_d.bits[D_W-6 -: SIZE_W];
    a_fire = a_deq_valid && a_deq_ready;
    d_fire = out_d.valid && d_enq_ready;
    d_last = d_rem == '0 ? extra(d_size, d_data) == '0 : d_rem == BW'(1);
    inc = MAX_INFLIGHT > 0 && a_fire && a_first;
    dec = MAX_INFLIGHT > 0 && d_fire && d_last && inflight_q != '0;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      a_rem <= '0;
      d_rem <= '0;
      inflight_q <= '0;
    end else begin
      if (a_fire) a_rem <= a_first ? extra(a_size, a_data) : a_rem - 1'b1;
      if (d_fire) d_rem <= d_rem == '0 ? extra(d_size, d_data) : d_rem - 1'b1;
      inflight_q <= inflight_q + IF_W'(inc) - IF_W'(dec);
    end
  end
endmodule

// File: tb/tb_tl_buffer_param.sv
// tb_tl_buffer_param: directed self-checking bench for tl_buffer_param (default+limiter instance and flow/pipe instance)
module tb_tl_buffer_param;
  localparam int A_W = 90;
  localparam int D_W = 48;
  logic clock = 1'b0;
  logic reset;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  tl_buffer_param_if #(.W(A_W)) a0i (), a0o (), a1i (), a1o ();
  tl_buffer_param_if #(.W(D_W)) d0o (), d0i (), d1o (), d1i ();
  logic [1:0] a0c, d0c, a1c, d1c, f0;
  logic f1;
  tl_buffer_param #(.MAX_INFLIGHT(2)) u0 (
    .clock(clock), .reset(reset), .in_a(a0i), .out_a(a0o), .out_d(d0o), .in_d(d0i),
    .a_count(a0c), .d_count(d0c), .inflight(f0)
  );
  tl_buffer_param #(.A_FLOW(1), .A_PIPE(1)) u1 (
    .clock(clock), .reset(reset), .in_a(a1i), .out_a(a1o), .out_d(d1o), .in_d(d1i),
    .a_count(a1c), .d_count(d1c), .inflight(f1)
  );
  function automatic logic [A_W-1:0] abeat(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [31:0] data);
    return {op, 3'd5, sz, src, 32'h1000_0000 + 32'(src), 7'h2b, 4'hf, data, 1'b1};
  endfunction
  function automatic logic [D_W-1:0] dbeat(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src, input logic [31:0] data);
    return {op, 2'd1, sz, src, 1'b0, 1'b0, data, 1'b0};
  endfunction
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_chk++; if (a0i.ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_a_ready: got %b want 1", a0i.ready); end
    n_chk++; if (a0o.valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_a_valid: got %b want 0", a0o.valid); end
    n_chk++; if (d0i.valid !== 1'b0) begin n_fail++; $display("FAIL rst_in_d_valid: got %b want 0", d0i.valid); end
    n_chk++; if (d0o.ready !== 1'b1) begin n_fail++; $display("FAIL rst_out_d_ready: got %b want 1", d0o.ready); end
    n_chk++; if ({a0c, d0c, f0} !== 6'd0) begin n_fail++; $display("FAIL rst_counts: got %h want 0", {a0c, d0c, f0}); end
  endtask
  task automatic test_single_put();
    logic [A_W-1:0] p;
    p = abeat(3'd0, 4'd2, 4'd1, 32'hDEADBEEF);
    a0o.ready = 1'b1;
    d0i.ready = 1'b1;
    a0i.valid = 1'b1;
    a0i.bits = p;
    #1;
    n_chk++; if (a0o.valid !== 1'b0) begin n_fail++; $display("FAIL put_no_bypass: got %b want 0", a0o.valid); end
    tick();
    a0i.valid = 1'b0;
    #1;
    n_chk++; if (a0o.valid !== 1'b1) begin n_fail++; $display("FAIL put_valid: got %b want 1", a0o.valid); end
    n_chk++; if (a0o.bits !== p) begin n_fail++; $display("FAIL put_bits: got %h want %h", a0o.bits, p); end
    n_chk++; if (a0c !== 2'd1) begin n_fail++; $display("FAIL put_count1: got %0d want 1", a0c); end
    tick();
    n_chk++; if (a0c !== 2'd0) begin n_fail++; $display("FAIL put_count0: got %0d want 0", a0c); end
    n_chk++; if (f0 !== 2'd1) begin n_fail++; $display("FAIL put_inflight: got %0d want 1", f0); end
    d0o.valid = 1'b1;
    d0o.bits = dbeat(3'd0, 4'd2, 4'd1, 32'd0);
    tick();
    d0o.valid = 1'b0;
    #1;
    n_chk++; if (f0 !== 2'd0) begin n_fail++; $display("FAIL ack_inflight: got %0d want 0", f0); end
    n_chk++; if (d0c !== 2'd1) begin n_fail++; $display("FAIL ack_dcount: got %0d want 1", d0c); end
    n_chk++; if (d0i.bits !== dbeat(3'd0, 4'd2, 4'd1, 32'd0)) begin n_fail++; $display("FAIL ack_bits: got %h want %h", d0i.bits, dbeat(3'd0, 4'd2, 4'd1, 32'd0)); end
    tick();
    n_chk++; if (d0c !== 2'd0) begin n_fail++; $display("FAIL ack_drain: got %0d want 0", d0c); end
  endtask
  task automatic test_fill();
    logic [A_W-1:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = abeat(3'd0, 4'd4, 4'd2, 32'h1111_0000 + 32'(i));
    a0o.ready = 1'b0;
    a0i.valid = 1'b1;
    a0i.bits = b[0];
    tick();
    a0i.bits = b[1];
    tick();
    a0i.bits = b[2];
    #1;
    n_chk++; if (a0i.ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_ready: got %b want 0", a0i.ready); end
    n_chk++; if (a0c !== 2'd2) begin n_fail++; $display("FAIL fill_count: got %0d want 2", a0c); end
    tick();
    n_chk++; if (a0o.bits !== b[0]) begin n_fail++; $display("FAIL fill_head0: got %h want %h", a0o.bits, b[0]); end
    a0o.ready = 1'b1;
    #1;
    n_chk++; if (a0i.ready !== 1'b0) begin n_fail++; $display("FAIL fill_nopipe: got %b want 0", a0i.ready); end
    tick();
    n_chk++; if (a0i.ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_back: got %b want 1", a0i.ready); end
    n_chk++; if (a0o.bits !== b[1]) begin n_fail++; $display("FAIL fill_head1: got %h want %h", a0o.bits, b[1]); end
    tick();
    a0i.bits = b[3];
    #1;
    n_chk++; if (a0o.bits !== b[2]) begin n_fail++; $display("FAIL fill_head2: got %h want %h", a0o.bits, b[2]); end
    tick();
    a0i.valid = 1'b0;
    #1;
    n_chk++; if (a0o.bits !== b[3]) begin n_fail++; $display("FAIL fill_head3: got %h want %h", a0o.bits, b[3]); end
    n_chk++; if (a0c !== 2'd1) begin n_fail++; $display("FAIL fill_count_mid: got %0d want 1", a0c); end
    tick();
    n_chk++; if (a0c !== 2'd0) begin n_fail++; $display("FAIL fill_empty: got %0d want 0", a0c); end
    n_chk++; if (f0 !== 2'd1) begin n_fail++; $display("FAIL burst_inflight: got %0d want 1", f0); end
    d0o.valid = 1'b1;
    d0o.bits = dbeat(3'd0, 4'd4, 4'd2, 32'd0);
    tick();
    d0o.valid = 1'b0;
    #1;
    n_chk++; if (f0 !== 2'd0) begin n_fail++; $display("FAIL burst_ack: got %0d want 0", f0); end
    tick();
  endtask
  task automatic test_limiter();
    logic [A_W-1:0] g [3];
    for (int i = 0; i < 3; i++) g[i] = abeat(3'd4, 4'd2, 4'(i + 4), 32'd0);
    a0o.ready = 1'b1;
    a0i.valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a0i.bits = g[i];
      tick();
    end
    a0i.valid = 1'b0;
    #1;
    n_chk++; if (a0o.valid !== 1'b0) begin n_fail++; $display("FAIL lim_gated: got %b want 0", a0o.valid); end
    n_chk++; if (f0 !== 2'd2) begin n_fail++; $display("FAIL lim_inflight2: got %0d want 2", f0); end
    tick();
    n_chk++; if (a0c !== 2'd1) begin n_fail++; $display("FAIL lim_held: got %0d want 1", a0c); end
    d0o.valid = 1'b1;
    d0o.bits = dbeat(3'd1, 4'd2, 4'd4, 32'hCAFE0001);
    tick();
    d0o.valid = 1'b0;
    #1;
    n_chk++; if (f0 !== 2'd1) begin n_fail++; $display("FAIL lim_dec: got %0d want 1", f0); end
    n_chk++; if (a0o.valid !== 1'b1) begin n_fail++; $display("FAIL lim_release: got %b want 1", a0o.valid); end
    n_chk++; if (a0o.bits !== g[2]) begin n_fail++; $display("FAIL lim_third: got %h want %h", a0o.bits, g[2]); end
    tick();
    n_chk++; if (f0 !== 2'd2) begin n_fail++; $display("FAIL lim_issue: got %0d want 2", f0); end
    n_chk++; if (a0c !== 2'd0) begin n_fail++; $display("FAIL lim_empty: got %0d want 0", a0c); end
  endtask
  task automatic test_burst_d();
    d0o.valid = 1'b1;
    d0o.bits = dbeat(3'd1, 4'd4, 4'd5, 32'hB0B0B0B0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++; if (f0 !== 2'd2) begin n_fail++; $display("FAIL dburst_beat%0d: got %0d want 2", i, f0); end
    end
    tick();
    n_chk++; if (f0 !== 2'd1) begin n_fail++; $display("FAIL dburst_last: got %0d want 1", f0); end
    d0o.bits = dbeat(3'd1, 4'd2, 4'd6, 32'h0);
    tick();
    d0o.valid = 1'b0;
    #1;
    n_chk++; if (f0 !== 2'd0) begin n_fail++; $display("FAIL dburst_single: got %0d want 0", f0); end
    tick();
    tick();
  endtask
  task automatic test_flow_pipe();
    logic [A_W-1:0] x, y, z, w;
    x = abeat(3'd0, 4'd2, 4'd8, 32'hA5A5A5A5);
    y = abeat(3'd4, 4'd2, 4'd9, 32'd0);
    z = abeat(3'd4, 4'd2, 4'd10, 32'd0);
    w = abeat(3'd4, 4'd2, 4'd11, 32'd0);
    a1o.ready = 1'b1;
    a1i.valid = 1'b1;
    a1i.bits = x;
    #1;
    n_chk++; if (a1o.valid !== 1'b1) begin n_fail++; $display("FAIL flow_valid: got %b want 1", a1o.valid); end
    n_chk++; if (a1o.bits !== x) begin n_fail++; $display("FAIL flow_bits: got %h want %h", a1o.bits, x); end
    tick();
    n_chk++; if (a1c !== 2'd0) begin n_fail++; $display("FAIL flow_count: got %0d want 0", a1c); end
    n_chk++; if (f1 !== 1'b0) begin n_fail++; $display("FAIL flow_inflight: got %0d want 0", f1); end
    a1o.ready = 1'b0;
    a1i.bits = y;
    tick();
    a1i.bits = z;
    tick();
    a1i.bits = w;
    #1;
    n_chk++; if (a1i.ready !== 1'b0) begin n_fail++; $display("FAIL pipe_stall: got %b want 0", a1i.ready); end
    a1o.ready = 1'b1;
    #1;
    n_chk++; if (a1i.ready !== 1'b1) begin n_fail++; $display("FAIL pipe_ready: got %b want 1", a1i.ready); end
    n_chk++; if (a1o.bits !== y) begin n_fail++; $display("FAIL pipe_head: got %h want %h", a1o.bits, y); end
    tick();
    a1i.valid = 1'b0;
    #1;
    n_chk++; if (a1c !== 2'd2) begin n_fail++; $display("FAIL pipe_count: got %0d want 2", a1c); end
    n_chk++; if (a1o.bits !== z) begin n_fail++; $display("FAIL pipe_next: got %h want %h", a1o.bits, z); end
    tick();
    n_chk++; if (a1o.bits !== w) begin n_fail++; $display("FAIL pipe_last: got %h want %h", a1o.bits, w); end
    tick();
    n_chk++; if (a1c !== 2'd0) begin n_fail++; $display("FAIL pipe_drain: got %0d want 0", a1c); end
  endtask
  task automatic test_reset_mid();
    a0o.ready = 1'b1;
    a0i.valid = 1'b1;
    a0i.bits = abeat(3'd4, 4'd2, 4'd12, 32'd0);
    tick();
    a0i.bits = abeat(3'd4, 4'd2, 4'd13, 32'd0);
    tick();
    a0o.ready = 1'b0;
    a0i.bits = abeat(3'd4, 4'd2, 4'd14, 32'd0);
    tick();
    a0i.valid = 1'b0;
    #1;
    n_chk++; if (a0c !== 2'd2) begin n_fail++; $display("FAIL mid_count: got %0d want 2", a0c); end
    n_chk++; if (f0 !== 2'd1) begin n_fail++; $display("FAIL mid_inflight: got %0d want 1", f0); end
    reset = 1'b1;
    tick();
    n_chk++; if (a0c !== 2'd0) begin n_fail++; $display("FAIL mid_rst_count: got %0d want 0", a0c); end
    n_chk++; if (f0 !== 2'd0) begin n_fail++; $display("FAIL mid_rst_inflight: got %0d want 0", f0); end
    n_chk++; if (a0o.valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b want 0", a0o.valid); end
    n_chk++; if (a0i.ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready: got %b want 1", a0i.ready); end
    reset = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    a0i.valid = 1'b0; a0i.bits = '0; a0o.ready = 1'b0;
    d0o.valid = 1'b0; d0o.bits = '0; d0i.ready = 1'b1;
    a1i.valid = 1'b0; a1i.bits = '0; a1o.ready = 1'b0;
    d1o.valid = 1'b0; d1o.bits = '0; d1i.ready = 1'b1;
    test_reset();
    test_single_put();
    test_fill();
    test_limiter();
    test_burst_d();
    test_flow_pipe();
    test_reset_mid();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
